master_feed_sched: RTL and testbench

Epoch sequencer for `master_top`. It resets and enables the master, then issues per-epoch read addresses to the control-data SRAM (next_arr / mi_j / mj_i / proposal_nums) and to the v_gidx SRAM, keeping the required 3-epoch v_gidx skew. It drains the skewed v_gidx stream after the last epoch and waits for the master's `finish`. It sits between the top-level run control and `master_top` plus its input SRAMs, replacing the bench-driven feed.

---
 rtl/master_pkg.sv | 18 +
 rtl/sat_down_counter.sv | 27 ++
 rtl/master_feed_sched.sv | 159 +++++++++++++++
 tb/tb_master_feed_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_pkg.sv
// rtl/master_pkg.sv - shared epoch constants and sequencer state encoding
package master_pkg;

  localparam int NUM_EPOCH = 256;
  localparam int EPOCH_BW  = $clog2(NUM_EPOCH);
  localparam int V_SKEW    = 3;

  typedef enum logic [2:0] {
    IDLE,
    RST_M,
    PRIME,
    RUN,
    DRAIN,
    WAIT_FIN,
    DONE
  } state_t;

endpackage

// File: rtl/sat_down_counter.sv
// rtl/sat_down_counter.sv - loadable down counter that sticks at zero
module sat_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/master_feed_sched.sv
// rtl/master_feed_sched.sv - epoch sequencer feeding master_top and its control/v_gidx SRAMs
module master_feed_sched #(
  parameter int NUM_EPOCH = master_pkg::NUM_EPOCH,
  parameter int EPOCH_BW  = master_pkg::EPOCH_BW,
  parameter int V_SKEW    = master_pkg::V_SKEW,
  parameter int PRIME_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [EPOCH_BW-1:0] master_epoch,
  input  logic                master_finish,
  output logic                master_rst_n,
  output logic                master_enable,
  output logic                ctrl_rd_en,
  output logic [EPOCH_BW-1:0] ctrl_rd_addr,
  output logic                vg_rd_en,
  output logic [EPOCH_BW-1:0] vg_rd_addr,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  import master_pkg::*;

  localparam int PW = $clog2(PRIME_CYC) + 1;
  localparam int DW = $clog2(V_SKEW) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [EPOCH_BW-1:0] LAST = EPOCH_BW'(NUM_EPOCH - 1);

  state_t state;

  logic                prime_zero, drain_zero, to_zero;
  logic                prime_load, drain_load, to_load;
  logic                in_feed, timed_out, go_done;
  logic [EPOCH_BW:0]   vg_diff;
  logic [EPOCH_BW-1:0] vg_clamp;

  // v_gidx trails the control data; the extra bit catches underflow in early epochs
  assign vg_diff  = {1'b0, master_epoch} - (EPOCH_BW + 1)'(V_SKEW);
  assign vg_clamp = vg_diff[EPOCH_BW] ? '0 : vg_diff[EPOCH_BW-1:0];

  assign prime_load = (state == RST_M);
  assign drain_load = (state == RUN) && (master_epoch == LAST);
  assign to_load    = (state == DRAIN) && drain_zero;

  // A finish during IDLE/RST_M/DONE is stale from a previous run and is not acted on
  assign in_feed   = (state == PRIME) || (state == RUN) || (state == DRAIN) || (state == WAIT_FIN);
  assign timed_out = (state == WAIT_FIN) && to_zero && !master_finish;
  assign go_done   = (in_feed && master_finish) || timed_out;

  sat_down_counter #(.W(PW)) u_prime_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (prime_load),
    .load_val (PW'(PRIME_CYC - 1)),
    .dec      (state == PRIME),
    .zero     (prime_zero)
  );

  sat_down_counter #(.W(DW)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DW'(V_SKEW - 1)),
    .dec      (state == DRAIN),
    .zero     (drain_zero)
  );

  sat_down_counter #(.W(TW)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (state == WAIT_FIN),
    .zero     (to_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      master_rst_n  <= 1'b0;
      master_enable <= 1'b0;
      ctrl_rd_en    <= 1'b0;
      vg_rd_en      <= 1'b0;
      ctrl_rd_addr  <= '0;
      vg_rd_addr    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go_done) begin
        state         <= DONE;
        done          <= 1'b1;
        master_enable <= 1'b0;
        ctrl_rd_en    <= 1'b0;
        vg_rd_en      <= 1'b0;
        busy          <= 1'b0;
        if (timed_out) begin
          timeout_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            master_rst_n <= 1'b1;
            if (start) begin
              state         <= RST_M;
              master_rst_n  <= 1'b0;
              master_enable <= 1'b0;
              ctrl_rd_en    <= 1'b1;
              vg_rd_en      <= 1'b1;
              ctrl_rd_addr  <= '0;
              vg_rd_addr    <= '0;
              busy          <= 1'b1;
              timeout_err   <= 1'b0;
            end
          end
          RST_M: begin
            state         <= PRIME;
            master_rst_n  <= 1'b1;
            master_enable <= 1'b1;
          end
          PRIME: begin
            if (prime_zero) begin
              state        <= RUN;
              ctrl_rd_addr <= master_epoch;
              vg_rd_addr   <= vg_clamp;
            end
          end
          RUN: begin
            ctrl_rd_addr <= master_epoch;
            vg_rd_addr   <= vg_clamp;
            if (master_epoch == LAST) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            vg_rd_addr <= vg_rd_addr + EPOCH_BW'(1);
            if (drain_zero) begin
              state <= WAIT_FIN;
            end
          end
          WAIT_FIN: begin
            state <= WAIT_FIN;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_feed_sched.sv
// tb/tb_master_feed_sched.sv - directed scenario bench for master_feed_sched
module tb_master_feed_sched;

  localparam int T = 1024;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] master_epoch;
  logic       master_finish;
  logic       master_rst_n;
  logic       master_enable;
  logic       ctrl_rd_en;
  logic [7:0] ctrl_rd_addr;
  logic       vg_rd_en;
  logic [7:0] vg_rd_addr;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  master_feed_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .master_epoch  (master_epoch),
    .master_finish (master_finish),
    .master_rst_n  (master_rst_n),
    .master_enable (master_enable),
    .ctrl_rd_en    (ctrl_rd_en),
    .ctrl_rd_addr  (ctrl_rd_addr),
    .vg_rd_en      (vg_rd_en),
    .vg_rd_addr    (vg_rd_addr),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Master epoch counts up one per cycle from cycle 2, saturating at 255
  function automatic int epoch_nom(input int n);
    if (n < 2) return 0;
    if (n - 2 > 255) return 255;
    return n - 2;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, done, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, done, timeout_err});
    end
    checks++;
    if ({ctrl_rd_addr, vg_rd_addr} !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr got=%0d/%0d exp=0/0", ctrl_rd_addr, vg_rd_addr);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (master_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rst_n=%b busy=%b exp rst_n=1 busy=0", master_rst_n, busy);
    end
  endtask

  task automatic test_nominal();
    int ec, ev;
    start         = 1'b1;
    master_epoch  = 8'd0;
    master_finish = 1'b0;
    for (int n = 1; n <= 264; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if ({master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, timeout_err} !== 6'b001110) begin
          errors++;
          $display("FAIL nom_rstm got=%b exp=001110",
                   {master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, timeout_err});
        end
      end
      if (n == 2) begin
        checks++;
        if (master_rst_n !== 1'b1 || master_enable !== 1'b1) begin
          errors++;
          $display("FAIL nom_prime got rst_n=%b en=%b exp 1/1", master_rst_n, master_enable);
        end
      end
      if (n == 3) begin
        checks++;
        if (ctrl_rd_addr !== 8'd0 || vg_rd_addr !== 8'd0) begin
          errors++;
          $display("FAIL nom_prime_addr got=%0d/%0d exp=0/0", ctrl_rd_addr, vg_rd_addr);
        end
      end
      if (n >= 4 && n <= 258) begin
        ec = epoch_nom(n - 1);
        ev = (ec < 3) ? 0 : ec - 3;
        checks++;
        if (ctrl_rd_addr !== 8'(ec) || vg_rd_addr !== 8'(ev)) begin
          errors++;
          $display("FAIL nom_run_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", n, ctrl_rd_addr, vg_rd_addr, ec, ev);
        end
      end
      if (n >= 259 && n <= 261) begin
        checks++;
        if (ctrl_rd_addr !== 8'd255 || vg_rd_addr !== 8'(252 + n - 258)) begin
          errors++;
          $display("FAIL nom_drain cyc=%0d got=%0d/%0d exp=255/%0d", n, ctrl_rd_addr, vg_rd_addr, 252 + n - 258);
        end
      end
      if (n == 262) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || master_enable !== 1'b1) begin
          errors++;
          $display("FAIL nom_wait got busy=%b done=%b en=%b exp 1/0/1", busy, done, master_enable);
        end
      end
      if (n == 263) begin
        checks++;
        if ({done, busy, timeout_err, master_enable, ctrl_rd_en, vg_rd_en} !== 6'b100000) begin
          errors++;
          $display("FAIL nom_done got=%b exp=100000", {done, busy, timeout_err, master_enable, ctrl_rd_en, vg_rd_en});
        end
      end
      if (n == 264) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL nom_done_pulse got done=%b busy=%b exp 0/0", done, busy);
        end
      end
      start         = 1'b0;
      master_epoch  = 8'(epoch_nom(n));
      master_finish = (n == 262);
    end
    master_finish = 1'b0;
  endtask

  task automatic test_timeout();
    start         = 1'b1;
    master_epoch  = 8'd0;
    master_finish = 1'b0;
    for (int n = 1; n <= 261 + T + 2; n++) begin
      @(negedge clk);
      if (n == 261) begin
        checks++;
        if (ctrl_rd_addr !== 8'd255 || vg_rd_addr !== 8'd255 || busy !== 1'b1) begin
          errors++;
          $display("FAIL to_wait_entry got=%0d/%0d busy=%b exp=255/255 busy=1", ctrl_rd_addr, vg_rd_addr, busy);
        end
      end
      if (n == 261 + T - 1) begin
        checks++;
        if (done !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL to_early got done=%b err=%b busy=%b exp 0/0/1", done, timeout_err, busy);
        end
      end
      if (n == 261 + T) begin
        checks++;
        if (done !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL to_fire got done=%b err=%b busy=%b exp 1/1/0", done, timeout_err, busy);
        end
      end
      if (n == 261 + T + 1 || n == 261 + T + 2) begin
        checks++;
        if (done !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL to_sticky cyc=%0d got done=%b err=%b busy=%b exp 0/1/0", n, done, timeout_err, busy);
        end
      end
      start        = (n == 261 + T);
      master_epoch = 8'(epoch_nom(n));
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start         = 1'b1;
    master_epoch  = 8'd0;
    master_finish = 1'b0;
    for (int n = 1; n <= 103; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rmr_start_clear got err=%b busy=%b exp 0/1", timeout_err, busy);
        end
      end
      if (n == 102) begin
        checks++;
        if (ctrl_rd_addr !== 8'd99 || vg_rd_addr !== 8'd96) begin
          errors++;
          $display("FAIL rmr_before got=%0d/%0d exp=99/96", ctrl_rd_addr, vg_rd_addr);
        end
      end
      if (n == 103) begin
        checks++;
        if ({master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, done, timeout_err} !== 7'b0 ||
            ctrl_rd_addr !== 8'd0 || vg_rd_addr !== 8'd0) begin
          errors++;
          $display("FAIL rmr_reset got flags=%b addr=%0d/%0d exp 0000000 0/0",
                   {master_rst_n, master_enable, ctrl_rd_en, vg_rd_en, busy, done, timeout_err},
                   ctrl_rd_addr, vg_rd_addr);
        end
      end
      start        = 1'b0;
      master_epoch = 8'(epoch_nom(n));
      rst          = (n == 102);
    end
    rst = 1'b0;
  endtask

  task automatic test_stall_ignored_start();
    int e;
    start         = 1'b1;
    master_epoch  = 8'd0;
    master_finish = 1'b0;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n >= 53 && n <= 57) begin
        checks++;
        if (ctrl_rd_addr !== 8'd50 || vg_rd_addr !== 8'd47) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got=%0d/%0d exp=50/47", n, ctrl_rd_addr, vg_rd_addr);
        end
      end
      if (n == 58) begin
        checks++;
        if (ctrl_rd_addr !== 8'd51 || vg_rd_addr !== 8'd48) begin
          errors++;
          $display("FAIL stall_resume got=%0d/%0d exp=51/48", ctrl_rd_addr, vg_rd_addr);
        end
      end
      if (n == 61) begin
        checks++;
        if (ctrl_rd_addr !== 8'd54 || vg_rd_addr !== 8'd51 || master_rst_n !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL ign_start got=%0d/%0d rst_n=%b busy=%b exp=54/51 1 1",
                   ctrl_rd_addr, vg_rd_addr, master_rst_n, busy);
        end
      end
      if (n == 71) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL early_finish got done=%b busy=%b err=%b exp 1/0/0", done, busy, timeout_err);
        end
      end
      if (n == 72) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL early_finish_pulse got done=%b exp 0", done);
        end
      end
      if (n < 2) e = 0;
      else if (n <= 52) e = n - 2;
      else if (n <= 56) e = 50;
      else e = n - 6;
      start         = (n == 60);
      master_epoch  = 8'(e);
      master_finish = (n == 70);
    end
    start         = 1'b0;
    master_finish = 1'b0;
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    start         = 1'b0;
    master_epoch  = 8'd0;
    master_finish = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_reset_mid_run();
    test_nominal();
    test_stall_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
